// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter stage of the single-cycle CPU. Holds the instruction-ROM
//   address, offers PC+1 to the ROM-select mux, and adds call/return through
//   a small hardware return-address stack plus a terminal HALT state.
//
// Ports
//   clk             in   system clock, rising-edge active
//   rst_n           in   asynchronous active-low reset
//   enable          in   1 = advance this cycle, 0 = stall (all state held)
//   next_addr       in   next address chosen by the ROM-select mux
//   call            in   current instruction is a call (push PC+1, jump)
//   ret             in   current instruction is a return (pop into PC)
//   halt            in   current instruction is a halt
//   pc              out  current instruction-ROM address (registered)
//   pc_plus1        out  pc + 1, wrapping, combinational
//   halted          out  1 while in HALT
//   stack_depth     out  number of valid return-stack entries
//   stack_overflow  out  sticky: call seen while the stack was full
//   stack_underflow out  sticky: return seen while the stack was empty
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter int                    STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [ADDR_WIDTH-1:0]        next_addr,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         halt,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic [ADDR_WIDTH-1:0]        pc_plus1,
    output logic                         halted,
    output logic [$clog2(STACK_DEPTH):0] stack_depth,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int PW = IW + 1;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]            state, state_d;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [PW-1:0]         depth_d;
    logic                  ovf_d, unf_d;
    logic                  push;
    logic                  stack_full, stack_empty;
    logic [IW-1:0]         push_idx, top_idx;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    assign pc_plus1    = pc + ADDR_WIDTH'(1);
    assign halted      = (state == HALT);
    assign stack_full  = (stack_depth == PW'(STACK_DEPTH));
    assign stack_empty = (stack_depth == '0);
    // Only used when the stack is not full / not empty, so truncation is safe.
    assign push_idx    = IW'(stack_depth);
    assign top_idx     = IW'(stack_depth - PW'(1));

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        depth_d = stack_depth;
        ovf_d   = stack_overflow;
        unf_d   = stack_underflow;
        push    = 1'b0;
        if (state == RUN && enable) begin
            if (halt) begin
                // PC stays on the halt instruction.
                state_d = HALT;
            end else if (ret) begin
                // Return wins over a simultaneous call; no push happens.
                if (!stack_empty) begin
                    pc_d    = stack_mem[top_idx];
                    depth_d = stack_depth - PW'(1);
                end else begin
                    pc_d  = pc_plus1;
                    unf_d = 1'b1;
                end
            end else if (call) begin
                pc_d = next_addr;
                if (!stack_full) begin
                    push    = 1'b1;
                    depth_d = stack_depth + PW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                pc_d = next_addr;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            pc              <= RESET_ADDR;
            stack_depth     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            // NOTE: the stack array is reset too, so no stale return address
            // survives a reset; this costs a reset on each entry.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            state           <= state_d;
            pc              <= pc_d;
            stack_depth     <= depth_d;
            stack_overflow  <= ovf_d;
            stack_underflow <= unf_d;
            if (push) begin
                stack_mem[push_idx] <= pc_plus1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: table-driven vectors fed through a scoreboard
// queue, plus hand-written asynchronous-reset sequences.
module tb_pc_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] next_addr = '0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       halt = 1'b0;
    logic [9:0] pc;
    logic [9:0] pc_plus1;
    logic       halted;
    logic [2:0] stack_depth;
    logic       stack_overflow;
    logic       stack_underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       en;
        logic [9:0] na;
        logic       cl;
        logic       rt;
        logic       hl;
        logic [9:0] pc;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
        logic       hlt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    pc_fetch_unit #(
        .ADDR_WIDTH (10),
        .RESET_ADDR (10'd0),
        .STACK_DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .next_addr      (next_addr),
        .call           (call),
        .ret            (ret),
        .halt           (halt),
        .pc             (pc),
        .pc_plus1       (pc_plus1),
        .halted         (halted),
        .stack_depth    (stack_depth),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, input logic [9:0] na, input logic cl,
                                input logic rt, input logic hl, input logic [9:0] epc,
                                input logic [2:0] ed, input logic eo, input logic eu,
                                input logic eh);
        vec_t v;
        v.en = en; v.na = na; v.cl = cl; v.rt = rt; v.hl = hl;
        v.pc = epc; v.depth = ed; v.ovf = eo; v.unf = eu; v.hlt = eh;
        tbl.push_back(v);
    endfunction

    // Drive one vector at posedge+1, push its expectation, compare after the
    // next posedge (+1) when the DUT has produced the result.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        logic [9:0] exp_p1;
        enable = v.en; next_addr = v.na; call = v.cl; ret = v.rt; halt = v.hl;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        exp_p1 = e.pc + 10'd1;
        check($sformatf("v%0d pc", idx), pc, e.pc);
        check($sformatf("v%0d pc_plus1", idx), pc_plus1, exp_p1);
        check($sformatf("v%0d depth", idx), stack_depth, e.depth);
        check($sformatf("v%0d overflow", idx), stack_overflow, e.ovf);
        check($sformatf("v%0d underflow", idx), stack_underflow, e.unf);
        check($sformatf("v%0d halted", idx), halted, e.hlt);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end
        if (sb.size() != 0) begin
            check({tag, " scoreboard drained"}, sb.size(), 0);
        end
        tbl.delete();
    endtask

    task automatic idle();
        enable = 1'b0; next_addr = '0; call = 1'b0; ret = 1'b0; halt = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc"}, pc, 10'd0);
        check({tag, " halted"}, halted, 1'b0);
        check({tag, " depth"}, stack_depth, 3'd0);
        check({tag, " overflow"}, stack_overflow, 1'b0);
        check({tag, " underflow"}, stack_underflow, 1'b0);
    endtask

    initial begin
        // Power-on reset.
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   en  na      cl ret hl   pc      d  ovf unf hlt
        add(1, 10'd1,   0, 0, 0,  10'd1,   0, 0, 0, 0);
        add(1, 10'd2,   0, 0, 0,  10'd2,   0, 0, 0, 0);
        add(1, 10'd3,   0, 0, 0,  10'd3,   0, 0, 0, 0);
        add(1, 10'h3FF, 0, 0, 0,  10'h3FF, 0, 0, 0, 0);   // pc_plus1 wraps to 0
        add(1, 10'd0,   0, 0, 0,  10'd0,   0, 0, 0, 0);
        add(1, 10'd5,   0, 0, 0,  10'd5,   0, 0, 0, 0);
        add(1, 10'd40,  1, 0, 0,  10'd40,  1, 0, 0, 0);   // push 6
        add(1, 10'd41,  0, 0, 0,  10'd41,  1, 0, 0, 0);
        add(1, 10'd42,  0, 0, 0,  10'd42,  1, 0, 0, 0);
        add(1, 10'd80,  1, 0, 0,  10'd80,  2, 0, 0, 0);   // push 43
        add(1, 10'd0,   0, 1, 0,  10'd43,  1, 0, 0, 0);
        add(1, 10'd0,   0, 1, 0,  10'd6,   0, 0, 0, 0);
        add(1, 10'd100, 1, 0, 0,  10'd100, 1, 0, 0, 0);   // push 7
        add(1, 10'd200, 1, 0, 0,  10'd200, 2, 0, 0, 0);   // push 101
        add(1, 10'd300, 1, 0, 0,  10'd300, 3, 0, 0, 0);   // push 201
        add(1, 10'd400, 1, 0, 0,  10'd400, 4, 0, 0, 0);   // push 301
        add(1, 10'd500, 1, 0, 0,  10'd500, 4, 1, 0, 0);   // full: overflow
        add(1, 10'd600, 1, 1, 0,  10'd301, 3, 1, 0, 0);   // call+ret: pop only
        add(1, 10'd0,   0, 1, 0,  10'd201, 2, 1, 0, 0);
        add(1, 10'd0,   0, 1, 0,  10'd101, 1, 1, 0, 0);
        add(1, 10'd0,   0, 1, 0,  10'd7,   0, 1, 0, 0);
        add(1, 10'd12,  0, 0, 0,  10'd12,  0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            add(0, 10'd50, 1, 0, 0, 10'd12, 0, 1, 0, 0);  // stall with call
        end
        add(1, 10'd77,  0, 0, 1,  10'd12,  0, 1, 0, 1);   // halt
        add(1, 10'd99,  1, 0, 0,  10'd12,  0, 1, 0, 1);
        add(1, 10'd0,   0, 1, 0,  10'd12,  0, 1, 0, 1);
        run_table("t1");

        // Async reset while halted, between clock edges.
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset halt d0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        add(1, 10'd9,   0, 0, 0,  10'd9,   0, 0, 0, 0);
        add(1, 10'd0,   0, 1, 0,  10'd10,  0, 0, 1, 0);   // underflow
        add(1, 10'd20,  1, 0, 0,  10'd20,  1, 0, 1, 0);
        add(1, 10'd30,  1, 0, 0,  10'd30,  2, 0, 1, 0);
        add(1, 10'd0,   0, 0, 1,  10'd30,  2, 0, 1, 1);
        add(1, 10'd5,   1, 0, 0,  10'd30,  2, 0, 1, 1);
        run_table("t2");

        // Async reset mid-operation in HALT with two stack entries.
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset halt d2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
